// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcode values and datapath select encodings for the
// multi-cycle RV32I controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: funct3/funct7_5 to ALUControl, flagging unsupported
// funct3 values. funct7_5 only selects sub for register-register ops.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic       i_funct3_0,
    input  logic       i_funct3_1,
    input  logic       i_funct3_2,
    input  logic       i_funct7_5,
    input  logic       i_rtype,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal
);

    logic [2:0] w_funct3;
    assign w_funct3 = {i_funct3_2, i_funct3_1, i_funct3_0};

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_illegal  = 1'b0;
        case (w_funct3)
            3'b000:  o_alu_ctrl = (i_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  o_alu_ctrl = ALU_AND;
            3'b110:  o_alu_ctrl = ALU_OR;
            3'b010:  o_alu_ctrl = ALU_SLT;
            default: o_illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM. Define DMEM_WAIT_EN to add the mem_ready
// handshake that stretches MEMRD/MEMWR until data memory completes.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 7,
    parameter int STATE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                Zero,
`ifdef DMEM_WAIT_EN
    input  logic                mem_ready,
`endif
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic                JumpSrc,
    output logic [2:0]          ImmSrc,
    output logic                ALUSrc,
    output logic [2:0]          ALUControl,
    output logic [1:0]          ResultSrc,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                Halt
);

    logic [STATE_WIDTH-1:0] r_state;
    state_t                 w_state;
    state_t                 w_next;
    logic                   w_mem_ready;
    logic [2:0]             w_alu_ctrl;
    logic                   w_alu_illegal;
    logic                   w_br_legal;
    logic                   w_br_taken;

`ifdef DMEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_state    = state_t'(r_state);
    assign w_br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign w_br_taken = funct3[0] ? ~Zero : Zero;

    mc_alu_dec u_alu_dec (
        .i_funct3_0 (funct3[0]),
        .i_funct3_1 (funct3[1]),
        .i_funct3_2 (funct3[2]),
        .i_funct7_5 (funct7_5),
        .i_rtype    (w_state == S_EXEC_R),
        .o_alu_ctrl (w_alu_ctrl),
        .o_illegal  (w_alu_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Outputs are forced low for the whole time rst is high, so an in-flight
    // write is cut off at the reset edge rather than at the next clock.
    always_comb begin
        w_next     = w_state;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        JumpSrc    = 1'b0;
        ImmSrc     = IMM_I;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALU;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Halt       = 1'b0;
        if (!rst) begin
            case (w_state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    w_next  = S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXEC_R;
                        OP_ITYPE:          w_next = S_EXEC_I;
                        OP_BRANCH:         w_next = S_BRANCH;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_LUI:            w_next = S_LUI;
                        default:           w_next = S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrc = 1'b1;
                    ImmSrc = (op == OP_STORE) ? IMM_S : IMM_I;
                    w_next = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    if (w_mem_ready) w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = RES_MEM;
                    RegWrite  = 1'b1;
                    PCWrite   = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    if (w_mem_ready) begin
                        PCWrite = 1'b1;
                        w_next  = S_FETCH;
                    end
                end
                S_EXEC_R, S_EXEC_I: begin
                    ALUSrc     = (w_state == S_EXEC_I);
                    ALUControl = w_alu_ctrl;
                    w_next     = w_alu_illegal ? S_HALT : S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    ALUControl = ALU_SUB;
                    ImmSrc     = IMM_B;
                    if (w_br_legal) begin
                        PCWrite = 1'b1;
                        PCSrc   = w_br_taken;
                        w_next  = S_FETCH;
                    end else begin
                        w_next  = S_HALT;
                    end
                end
                S_JAL, S_JALR: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_PC4;
                    PCWrite   = 1'b1;
                    PCSrc     = 1'b1;
                    JumpSrc   = (w_state == S_JALR);
                    ImmSrc    = (w_state == S_JALR) ? IMM_I : IMM_J;
                    w_next    = S_FETCH;
                end
                S_LUI: begin
                    ALUSrc     = 1'b1;
                    ALUControl = ALU_PASSB;
                    ImmSrc     = IMM_U;
                    RegWrite   = 1'b1;
                    PCWrite    = 1'b1;
                    w_next     = S_FETCH;
                end
                S_HALT: Halt = 1'b1;
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control words are queued by
// the stimulus and compared by a negedge monitor.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7_5 = 1'b0;
    logic       Zero = 1'b0;
`ifdef DMEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       IRWrite, PCWrite, PCSrc, JumpSrc, ALUSrc, RegWrite, MemWrite, Halt;
    logic [2:0] ImmSrc, ALUControl;
    logic [1:0] ResultSrc;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .Zero       (Zero),
`ifdef DMEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .JumpSrc    (JumpSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Halt       (Halt)
    );

    // Control word: IR PCW PCS JS IMM[3] ALUS ALUC[3] RS[2] RW MW HALT
    logic [15:0] act;
    assign act = {IRWrite, PCWrite, PCSrc, JumpSrc, ImmSrc, ALUSrc, ALUControl,
                  ResultSrc, RegWrite, MemWrite, Halt};

    localparam logic [15:0] EN     = 16'hC007;
    localparam logic [15:0] M_PCS  = 16'h2000;
    localparam logic [15:0] M_JS   = 16'h1000;
    localparam logic [15:0] M_IMM  = 16'h0E00;
    localparam logic [15:0] M_ALUS = 16'h0100;
    localparam logic [15:0] M_ALUC = 16'h00E0;
    localparam logic [15:0] M_RS   = 16'h0018;
    localparam logic [15:0] ALL    = 16'hFFFF;
    localparam logic [15:0] ZW     = 16'h0000;

    typedef struct {
        string       nm;
        logic [15:0] e;
        logic [15:0] m;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] mk(int ir, int pcw, int pcs, int js, int imm,
                                       int alus, int aluc, int rs, int rw, int mw, int h);
        return {ir[0], pcw[0], pcs[0], js[0], imm[2:0], alus[0], aluc[2:0],
                rs[1:0], rw[0], mw[0], h[0]};
    endfunction

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e,
                       input logic [15:0] m);
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s actual=%h required=%h mask=%h", nm, a & m, e & m, m);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            chk(mon_x.nm, act, mon_x.e, mon_x.m);
        end
    end

    task automatic cyc(input string nm, input logic [15:0] e, input logic [15:0] m);
        exp_t x;
        x.nm = nm;
        x.e  = e;
        x.m  = m;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc("reset0", ZW, ALL);
        cyc("reset1", ZW, ALL);
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        op = o;
        funct3 = f3;
        funct7_5 = f75;
    endtask

    task automatic fetch_decode(input string nm);
        cyc({nm, "_fetch"}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), EN);
        cyc({nm, "_decode"}, ZW, EN);
    endtask

    task automatic alu_op(input string nm, input logic [6:0] o, input logic [2:0] f3,
                          input logic f75, input int aluc);
        int is_i;
        is_i = (o == 7'b0010011) ? 1 : 0;
        set_instr(o, f3, f75);
        fetch_decode(nm);
        if (is_i == 1)
            cyc({nm, "_exec"}, mk(0, 0, 0, 0, 'b000, 1, aluc, 0, 0, 0, 0), EN | M_ALUS | M_ALUC | M_IMM);
        else
            cyc({nm, "_exec"}, mk(0, 0, 0, 0, 0, 0, aluc, 0, 0, 0, 0), EN | M_ALUS | M_ALUC);
        cyc({nm, "_wb"}, mk(0, 1, 0, 0, 0, 0, 0, 'b00, 1, 0, 0), EN | M_PCS | M_RS);
    endtask

    task automatic branch(input string nm, input logic [2:0] f3, input logic z, input int pcs);
        set_instr(7'b1100011, f3, 1'b0);
        Zero = z;
        fetch_decode(nm);
        cyc({nm, "_br"}, mk(0, 1, pcs, 0, 'b010, 0, 'b001, 0, 0, 0, 0),
            EN | M_PCS | M_JS | M_IMM | M_ALUC);
        Zero = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // lw
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lw");
        cyc("lw_adr", mk(0, 0, 0, 0, 'b000, 1, 'b000, 0, 0, 0, 0), EN | M_IMM | M_ALUS | M_ALUC);
`ifdef DMEM_WAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", ZW, EN);
        mem_ready = 1'b1;
`endif
        cyc("lw_rd", ZW, EN);
        cyc("lw_wb", mk(0, 1, 0, 0, 0, 0, 0, 'b01, 1, 0, 0), EN | M_PCS | M_RS);

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("sw");
        cyc("sw_adr", mk(0, 0, 0, 0, 'b001, 1, 'b000, 0, 0, 0, 0), EN | M_IMM | M_ALUS | M_ALUC);
        cyc("sw_wr", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), EN | M_PCS);

        alu_op("add",  7'b0110011, 3'b000, 1'b0, 'b000);
        alu_op("sub",  7'b0110011, 3'b000, 1'b1, 'b001);
        alu_op("and",  7'b0110011, 3'b111, 1'b0, 'b010);
        alu_op("or",   7'b0110011, 3'b110, 1'b0, 'b011);
        alu_op("slt",  7'b0110011, 3'b010, 1'b0, 'b101);
        alu_op("addi", 7'b0010011, 3'b000, 1'b1, 'b000);
        alu_op("ori",  7'b0010011, 3'b110, 1'b0, 'b011);

        branch("beq_z1", 3'b000, 1'b1, 1);
        branch("beq_z0", 3'b000, 1'b0, 0);
        branch("bne_z1", 3'b001, 1'b1, 0);
        branch("bne_z0", 3'b001, 1'b0, 1);

        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal");
        cyc("jal_ex", mk(0, 1, 1, 0, 'b011, 0, 0, 'b10, 1, 0, 0), EN | M_PCS | M_JS | M_IMM | M_RS);

        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_decode("jalr");
        cyc("jalr_ex", mk(0, 1, 1, 1, 'b000, 0, 0, 'b10, 1, 0, 0), EN | M_PCS | M_JS | M_IMM | M_RS);

        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui");
        cyc("lui_ex", mk(0, 1, 0, 0, 'b100, 1, 'b110, 'b00, 1, 0, 0),
            EN | M_PCS | M_IMM | M_ALUS | M_ALUC | M_RS);

        // reset in the middle of a store write
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("swr");
        cyc("swr_adr", mk(0, 0, 0, 0, 'b001, 1, 'b000, 0, 0, 0, 0), EN | M_IMM | M_ALUS | M_ALUC);
        q.push_back('{nm: "swr_wr", e: mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), m: EN | M_PCS});
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_memwr", act, ZW, ALL);
        @(posedge clk);
        #1;
        cyc("rst_hold", ZW, ALL);
        rst = 1'b0;
        alu_op("after_rst", 7'b0110011, 3'b000, 1'b0, 'b000);

        // illegal R-type funct3
        set_instr(7'b0110011, 3'b001, 1'b0);
        fetch_decode("rbad");
        cyc("rbad_exec", ZW, EN);
        cyc("rbad_halt0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), EN);
        cyc("rbad_halt1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), EN);
        do_reset();

        // illegal branch funct3
        set_instr(7'b1100011, 3'b100, 1'b0);
        fetch_decode("bbad");
        cyc("bbad_br", ZW, EN);
        cyc("bbad_halt", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), EN);
        do_reset();

        // illegal opcode: absorbing halt
        set_instr(7'b1111111, 3'b000, 1'b0);
        fetch_decode("ill");
        for (int i = 0; i < 20; i++)
            cyc("ill_halt", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), EN);
        do_reset();

        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui2");
        cyc("lui2_ex", mk(0, 1, 0, 0, 'b100, 1, 'b110, 'b00, 1, 0, 0),
            EN | M_PCS | M_IMM | M_ALUS | M_ALUC | M_RS);

        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
